// File: rtl/core_fetch_stage.sv
//============================================================================
// core_fetch_stage
//   First pipeline stage of the LETC core: owns the PC, issues word fetches
//   with at most one request outstanding, buffers {pc, instr, fault} entries
//   and hands them to decode over valid/ready. Redirects flush the buffer and
//   discard any in-flight response.
//   Optional feature macro: LETC_FETCH_ACCESS_FAULT_EN (store/present access
//   faults and stop fetching after a faulting entry until the next redirect).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module core_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    output logic        o_d_valid,
    input  logic        i_d_ready,
    output logic [31:0] o_d_instr,
    output logic [31:0] o_d_pc,
    output logic        o_d_fault,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [31:0]      pc;
    logic [31:0]      buf_pc    [BUF_DEPTH];
    logic [31:0]      buf_instr [BUF_DEPTH];
    logic             buf_fault [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             fault_hold;
    logic             rsp_fault;
    logic             req_hs;
    logic             push;
    logic             pop;
    logic             not_empty;

`ifdef LETC_FETCH_ACCESS_FAULT_EN
    assign rsp_fault = i_imem_rsp_err;
`else
    // Fault reporting disabled: the error input is deliberately ignored.
    assign rsp_fault = i_imem_rsp_err & 1'b0;
`endif

    assign not_empty        = (count != '0);
    assign o_imem_req_valid = (state == S_REQ) && !i_rst;
    assign o_imem_addr      = pc;
    assign req_hs           = o_imem_req_valid && i_imem_req_ready;
    assign push             = (state == S_WAIT) && i_imem_rsp_valid && !i_redirect_valid;
    assign o_d_valid        = not_empty && !i_redirect_valid;
    assign pop              = o_d_valid && i_d_ready;
    assign o_d_instr        = not_empty ? buf_instr[rd_ptr] : 32'h0;
    assign o_d_pc           = not_empty ? buf_pc[rd_ptr]    : 32'h0;
    assign o_d_fault        = not_empty ? buf_fault[rd_ptr] : 1'b0;

    // Occupancy after this edge; a redirect flushes everything.
    always_comb begin
        count_next = count;
        if (i_redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Fetch FSM next-state; redirect handling takes priority in every state.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (req_hs) begin
                    // An accepted address under redirect still owes a response.
                    state_next = i_redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    state_next = i_imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (i_imem_rsp_valid) begin
                    if (rsp_fault)
                        state_next = S_HOLD;
                    else
                        state_next = (count_next < DEPTH_C) ? S_REQ : S_HOLD;
                end
            end
            S_DRAIN: begin
                if (i_imem_rsp_valid) begin
                    state_next = (count_next < DEPTH_C) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid)
                    state_next = S_REQ;
                else if (!fault_hold && (count_next < DEPTH_C))
                    state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // State, PC, buffer pointers and fault latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fault_hold <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (i_redirect_valid) begin
                pc         <= {i_redirect_pc[31:2], 2'b00};
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fault_hold <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (rsp_fault)
                        fault_hold <= 1'b1;
                    else
                        pc <= pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Buffer storage: written only on a push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= 32'h0;
                buf_instr[i] <= 32'h0;
                buf_fault[i] <= 1'b0;
            end
        end else if (push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= i_imem_rsp_data;
            buf_fault[wr_ptr] <= rsp_fault;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_fetch_stage.sv
//============================================================================
// tb_core_fetch_stage
//   Directed per-cycle vector table plus hand-written redirect/wrap/fault
//   sequences for core_fetch_stage.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_core_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_err = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        d_fault;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;

    int errors = 0;
    int checks = 0;

    core_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_d_valid        (d_valid),
        .i_d_ready        (d_ready),
        .o_d_instr        (d_instr),
        .o_d_pc           (d_pc),
        .o_d_fault        (d_fault),
        .i_redirect_valid (redir_valid),
        .i_redirect_pc    (redir_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rspv;
        logic [31:0] rdata;
        logic        dready;
        logic        redv;
        logic [31:0] redpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_dinstr;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, rdy, rspv, input logic [31:0] rdata,
                     input logic dready, redv, input logic [31:0] redpc,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic e_dv, input logic [31:0] e_dpc, e_dinstr);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rspv = rspv; t.rdata = rdata;
        t.dready = dready; t.redv = redv; t.redpc = redpc;
        t.e_rv = e_rv; t.e_addr = e_addr; t.e_dv = e_dv;
        t.e_dpc = e_dpc; t.e_dinstr = e_dinstr;
        vq.push_back(t);
    endtask

    // Apply inputs just after the edge, leave time to settle before checking.
    task automatic cyc(input logic r, rdy, rspv, input logic [31:0] rdata,
                       input logic err, dready, redv, input logic [31:0] redpc);
        @(posedge clk);
        #1;
        rst = r; req_ready = rdy; rsp_valid = rspv; rsp_data = rdata;
        rsp_err = err; d_ready = dready; redir_valid = redv; redir_pc = redpc;
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // rst rdy rspv rdata         drdy redv redpc | rv addr          dv dpc           dinstr
        v(1, 0, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h0,        0, 32'h0,        32'h0);
        v(0, 0, 1, 32'h1111_0000, 1, 0, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h4,        1, 32'h0,        32'h1111_0000);
        v(0, 0, 1, 32'h2222_0004, 1, 0, 32'h0,       0, 32'h4,        0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h8,        1, 32'h4,        32'h2222_0004);
        v(0, 0, 1, 32'h3333_0008, 1, 0, 32'h0,       0, 32'h8,        0, 32'h0,        32'h0);
        v(0, 0, 0, 32'h0,         1, 0, 32'h0,       1, 32'hC,        1, 32'h8,        32'h3333_0008);
        // decode stalled: fill the two-entry buffer, then hold
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       1, 32'hC,        0, 32'h0,        32'h0);
        v(0, 0, 1, 32'h4444_000C, 0, 0, 32'h0,       0, 32'hC,        0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h10,       1, 32'hC,        32'h4444_000C);
        v(0, 0, 1, 32'h5555_0010, 0, 0, 32'h0,       0, 32'h10,       1, 32'hC,        32'h4444_000C);
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h14,       1, 32'hC,        32'h4444_000C);
        v(0, 1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h14,       1, 32'hC,        32'h4444_000C);
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h14,       1, 32'h10,       32'h5555_0010);
        // redirect in WAIT without response; late response dropped in DRAIN
        v(0, 0, 0, 32'h0,         0, 1, 32'h100,     0, 32'h14,       0, 32'h10,       32'h5555_0010);
        v(0, 0, 0, 32'h0,         0, 0, 32'h0,       0, 32'h100,      0, 32'h0,        32'h0);
        v(0, 0, 1, 32'hDEAD_0014, 0, 0, 32'h0,       0, 32'h100,      0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h100,      0, 32'h0,        32'h0);
        v(0, 0, 1, 32'h6666_0100, 0, 0, 32'h0,       0, 32'h100,      0, 32'h0,        32'h0);
        // redirect coincident with a response, buffer non-empty
        v(0, 1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h104,      1, 32'h100,      32'h6666_0100);
        v(0, 0, 1, 32'hBAD0_0104, 1, 1, 32'h203,     0, 32'h104,      0, 32'h100,      32'h6666_0100);
        v(0, 0, 0, 32'h0,         1, 0, 32'h0,       1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h200,      0, 32'h0,        32'h0);
        v(0, 0, 1, 32'h7777_0200, 1, 0, 32'h0,       0, 32'h200,      0, 32'h0,        32'h0);
        v(0, 0, 0, 32'h0,         1, 0, 32'h0,       1, 32'h204,      1, 32'h200,      32'h7777_0200);
        // redirect while the old address is being accepted -> DRAIN
        v(0, 1, 0, 32'h0,         1, 1, 32'h300,     1, 32'h204,      0, 32'h0,        32'h0);
        v(0, 0, 1, 32'hDEAD_0204, 1, 0, 32'h0,       0, 32'h300,      0, 32'h0,        32'h0);
        v(0, 0, 0, 32'h0,         1, 0, 32'h0,       1, 32'h300,      0, 32'h0,        32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rst, vq[i].rdy, vq[i].rspv, vq[i].rdata, 1'b0,
                vq[i].dready, vq[i].redv, vq[i].redpc);
            chk($sformatf("row%0d req_valid", i), {31'b0, req_valid}, {31'b0, vq[i].e_rv});
            chk($sformatf("row%0d addr", i),      addr,               vq[i].e_addr);
            chk($sformatf("row%0d d_valid", i),   {31'b0, d_valid},   {31'b0, vq[i].e_dv});
            chk($sformatf("row%0d d_pc", i),      d_pc,               vq[i].e_dpc);
            chk($sformatf("row%0d d_instr", i),   d_instr,            vq[i].e_dinstr);
            chk($sformatf("row%0d d_fault", i),   {31'b0, d_fault},   32'h0);
        end

        // PC wrap at the top of the address space
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFF);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("wrap req_addr", addr, 32'hFFFF_FFFC);
        chk("wrap req_valid", {31'b0, req_valid}, 32'h1);
        cyc(0, 0, 1, 32'h8888_FFFC, 0, 0, 0, 32'h0);
        chk("wrap wait no req", {31'b0, req_valid}, 32'h0);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("wrap next addr", addr, 32'h0000_0000);
        chk("wrap next rv", {31'b0, req_valid}, 32'h1);
        chk("wrap d_pc", d_pc, 32'hFFFF_FFFC);
        chk("wrap d_instr", d_instr, 32'h8888_FFFC);
        cyc(0, 0, 0, 32'h0, 0, 1, 0, 32'h0);

        // Access fault at 0x40
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 32'h40);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("fault req_addr", addr, 32'h40);
        cyc(0, 0, 1, 32'h9999_0040, 1, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("fault d_valid", {31'b0, d_valid}, 32'h1);
        chk("fault d_pc", d_pc, 32'h40);
        chk("fault d_instr", d_instr, 32'h9999_0040);
`ifdef LETC_FETCH_ACCESS_FAULT_EN
        chk("fault d_fault", {31'b0, d_fault}, 32'h1);
        chk("fault stop rv", {31'b0, req_valid}, 32'h0);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("fault hold rv", {31'b0, req_valid}, 32'h0);
        cyc(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("fault hold empty rv", {31'b0, req_valid}, 32'h0);
        chk("fault hold empty dv", {31'b0, d_valid}, 32'h0);
`else
        chk("nofault d_fault", {31'b0, d_fault}, 32'h0);
        chk("nofault rv", {31'b0, req_valid}, 32'h1);
        chk("nofault addr", addr, 32'h44);
        cyc(0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("nofault pop rv", {31'b0, req_valid}, 32'h1);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("nofault empty dv", {31'b0, d_valid}, 32'h0);
        chk("nofault addr2", addr, 32'h44);
`endif
        cyc(0, 0, 0, 32'h0, 0, 0, 1, 32'h80);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("resume rv", {31'b0, req_valid}, 32'h1);
        chk("resume addr", addr, 32'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
